// File: rtl/clk_meas_pkg.sv
// Shared state encoding and default parameter values for the clock ratio meter.
package clk_meas_pkg;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      MEASURE    = 2'd1,
      LOCKED     = 2'd2
   } meas_state_e;

   localparam int DEF_CNT_W       = 16;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_LOCK_CNT    = 3;
   localparam int DEF_MAX_PERIOD  = 1023;

endpackage

// File: rtl/clk_ratio_meter_edge_sync.sv
// Optional synchronizer chain on the measured clock followed by rise/fall detection.
module edge_sync
   import clk_meas_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
)(
   input  logic clk,
   input  logic rst,
   input  logic clk_in,
   output logic s,
   output logic rise,
   output logic fall
);

   logic s_q_r;

   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign s = clk_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_r;

         // Shift clk_in through the synchronizer chain
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync_r <= {SYNC_STAGES{1'b0}};
            end else begin
               sync_r[0] <= clk_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_r[i] <= sync_r[i-1];
               end
            end
         end

         assign s = sync_r[SYNC_STAGES-1];
      end
   endgenerate

   // Delayed copy of the synchronized level for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q_r <= 1'b0;
      end else begin
         s_q_r <= s;
      end
   end

   assign rise = s & ~s_q_r;
   assign fall = ~s & s_q_r;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a divided clock, tracks lock and flags loss of edges.
module clk_ratio_meter
   import clk_meas_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int LOCK_CNT    = DEF_LOCK_CNT,
   parameter int MAX_PERIOD  = DEF_MAX_PERIOD
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             err,
   output logic             timeout
);

   localparam int                 MATCH_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0]   MAX_C   = CNT_W'(MAX_PERIOD);
   localparam logic [MATCH_W-1:0] LOCK_M  = MATCH_W'(LOCK_CNT);

   logic               s_s, rise_s, fall_s, timeout_hit_s;
   logic [CNT_W-1:0]   cnt_r, hcnt_r, ref_r, ref_n;
   logic               high_open_r, seen_rise_r;
   logic [MATCH_W-1:0] match_r, match_n;
   meas_state_e        state_r, state_n;
   logic [CNT_W-1:0]   period_r, period_n, high_time_r, high_time_n;
   logic               meas_valid_r, meas_valid_n, locked_r, locked_n;
   logic               err_r, err_n, timeout_r, timeout_n;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .clk_in (clk_in),
      .s      (s_s),
      .rise   (rise_s),
      .fall   (fall_s)
   );

   // Timeout is armed while measuring, and also after a timeout so a stuck clock keeps reporting
   assign timeout_hit_s = (cnt_r == MAX_C) && !rise_s &&
                          ((state_r != WAIT_FIRST) || seen_rise_r);

   // Period/high-time counters; a timeout restarts cnt so it fires again MAX_PERIOD cycles later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r       <= CNT_W'(0);
         hcnt_r      <= CNT_W'(0);
         high_open_r <= 1'b0;
         seen_rise_r <= 1'b0;
      end else begin
         if (rise_s || timeout_hit_s) begin
            cnt_r <= CNT_W'(1);
         end else if (cnt_r != MAX_C) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
         // high time covers the high phase that starts at the rise, up to its fall
         if (rise_s) begin
            hcnt_r      <= CNT_W'(1);
            high_open_r <= 1'b1;
            seen_rise_r <= 1'b1;
         end else begin
            if (s_s && high_open_r && (hcnt_r != MAX_C)) begin
               hcnt_r <= hcnt_r + CNT_W'(1);
            end else begin
               hcnt_r <= hcnt_r;
            end
            high_open_r <= fall_s ? 1'b0 : high_open_r;
            seen_rise_r <= seen_rise_r;
         end
      end
   end

   // Next-state and next-output decisions for the lock tracker
   always_comb begin
      state_n      = state_r;
      ref_n        = ref_r;
      match_n      = match_r;
      period_n     = period_r;
      high_time_n  = high_time_r;
      meas_valid_n = 1'b0;
      err_n        = 1'b0;
      timeout_n    = 1'b0;
      locked_n     = locked_r;
      case (state_r)
         WAIT_FIRST: begin
            if (rise_s) begin
               state_n = MEASURE;
               match_n = MATCH_W'(0);
            end else if (timeout_hit_s) begin
               timeout_n = 1'b1;
               err_n     = locked_r;
               locked_n  = 1'b0;
            end else begin
               state_n = WAIT_FIRST;
            end
         end
         MEASURE: begin
            if (rise_s) begin
               period_n     = cnt_r;
               high_time_n  = hcnt_r;
               meas_valid_n = 1'b1;
               // match==0 marks the first measurement after WAIT_FIRST
               if ((match_r != MATCH_W'(0)) && (cnt_r == ref_r)) begin
                  if (match_r >= LOCK_M) begin
                     match_n = LOCK_M;
                  end else begin
                     match_n = match_r + MATCH_W'(1);
                  end
               end else begin
                  ref_n   = cnt_r;
                  match_n = MATCH_W'(1);
               end
               if (match_n >= LOCK_M) begin
                  state_n  = LOCKED;
                  locked_n = 1'b1;
               end else begin
                  state_n  = MEASURE;
                  locked_n = 1'b0;
               end
            end else if (timeout_hit_s) begin
               timeout_n = 1'b1;
               err_n     = locked_r;
               locked_n  = 1'b0;
               match_n   = MATCH_W'(0);
               state_n   = WAIT_FIRST;
            end else begin
               state_n = MEASURE;
            end
         end
         LOCKED: begin
            if (rise_s) begin
               period_n     = cnt_r;
               high_time_n  = hcnt_r;
               meas_valid_n = 1'b1;
               if (cnt_r == ref_r) begin
                  state_n  = LOCKED;
                  locked_n = 1'b1;
               end else begin
                  err_n    = 1'b1;
                  locked_n = 1'b0;
                  ref_n    = cnt_r;
                  match_n  = MATCH_W'(1);
                  state_n  = MEASURE;
               end
            end else if (timeout_hit_s) begin
               timeout_n = 1'b1;
               err_n     = locked_r;
               locked_n  = 1'b0;
               match_n   = MATCH_W'(0);
               state_n   = WAIT_FIRST;
            end else begin
               state_n = LOCKED;
            end
         end
         default: begin
            state_n  = WAIT_FIRST;
            locked_n = 1'b0;
            match_n  = MATCH_W'(0);
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= WAIT_FIRST;
         ref_r        <= CNT_W'(0);
         match_r      <= MATCH_W'(0);
         period_r     <= CNT_W'(0);
         high_time_r  <= CNT_W'(0);
         meas_valid_r <= 1'b0;
         locked_r     <= 1'b0;
         err_r        <= 1'b0;
         timeout_r    <= 1'b0;
      end else begin
         state_r      <= state_n;
         ref_r        <= ref_n;
         match_r      <= match_n;
         period_r     <= period_n;
         high_time_r  <= high_time_n;
         meas_valid_r <= meas_valid_n;
         locked_r     <= locked_n;
         err_r        <= err_n;
         timeout_r    <= timeout_n;
      end
   end

   assign period     = period_r;
   assign high_time  = high_time_r;
   assign meas_valid = meas_valid_r;
   assign locked     = locked_r;
   assign err        = err_r;
   assign timeout    = timeout_r;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench: two meters (MAX_PERIOD 1023 and 8) checked against a rise-time model.
module tb_clk_ratio_meter;

   localparam int SYNC = 2;
   localparam int LOCKN = 3;
   localparam int LAT = SYNC + 1;   // drive cycle -> cycle the pulse is seen at the negedge

   typedef struct {
      bit          is_to;
      int unsigned per;
      int unsigned ht;
      bit          lk;
      bit          er;
      int unsigned cyc;
   } exp_t;

   logic clk, rst, clk_in0, clk_in8;
   logic [15:0] per0, ht0, per8, ht8;
   logic mv0, lk0, er0, to0, mv8, lk8, er8, to8;

   int checks = 0;
   int failures = 0;
   int unsigned cyc = 0;
   bit lvl [2];
   exp_t exp_q0[$];
   exp_t exp_q1[$];

   // reference model state, per instance
   int unsigned max_p [2];
   bit          m_prev [2];
   int          m_mode [2];   // 0 never seen a rise, 1 waiting after timeout, 2 measuring
   int unsigned m_last_rise [2], m_last_evt [2], m_high [2];
   int unsigned m_run_per [2], m_streak [2], m_per_out [2], m_ht_out [2];
   bit          m_locked [2];

   clk_ratio_meter #(.CNT_W(16), .SYNC_STAGES(SYNC), .LOCK_CNT(LOCKN), .MAX_PERIOD(1023)) u_dut0 (
      .clk(clk), .rst(rst), .clk_in(clk_in0), .period(per0), .high_time(ht0),
      .meas_valid(mv0), .locked(lk0), .err(er0), .timeout(to0));

   clk_ratio_meter #(.CNT_W(16), .SYNC_STAGES(SYNC), .LOCK_CNT(LOCKN), .MAX_PERIOD(8)) u_dut8 (
      .clk(clk), .rst(rst), .clk_in(clk_in8), .period(per8), .high_time(ht8),
      .meas_valid(mv8), .locked(lk8), .err(er8), .timeout(to8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int idx, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s[%0d] cyc=%0d actual=%0d expected=%0d", name, idx, cyc, act, exp);
      end
   endtask

   task automatic push(input int idx, input exp_t e);
      if (idx == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_prev[i] = 1'b0; m_mode[i] = 0; m_last_rise[i] = 0; m_last_evt[i] = 0;
         m_high[i] = 0; m_run_per[i] = 0; m_streak[i] = 0; m_per_out[i] = 0;
         m_ht_out[i] = 0; m_locked[i] = 1'b0;
      end
      exp_q0.delete();
      exp_q1.delete();
   endtask

   // Model: periods are distances between rises; lock = run of LOCKN equal periods
   task automatic model_step(input int idx, input bit v, input int unsigned c);
      exp_t e;
      int unsigned p;
      bit same;
      if (v && !m_prev[idx]) begin
         if (m_mode[idx] == 2) begin
            p = c - m_last_rise[idx];
            same = (m_streak[idx] > 0) && (p == m_run_per[idx]);
            e.er = m_locked[idx] && !same;
            m_streak[idx] = same ? m_streak[idx] + 1 : 1;
            m_run_per[idx] = p;
            m_locked[idx] = (m_streak[idx] >= LOCKN);
            m_per_out[idx] = p;
            m_ht_out[idx] = m_high[idx];
            e.is_to = 1'b0; e.per = p; e.ht = m_high[idx]; e.lk = m_locked[idx]; e.cyc = c;
            push(idx, e);
         end else begin
            m_mode[idx] = 2;
            m_streak[idx] = 0;
         end
         m_last_rise[idx] = c;
         m_last_evt[idx] = c;
         m_high[idx] = 0;
      end else if (m_mode[idx] != 0 && (c - m_last_evt[idx]) == max_p[idx]) begin
         e.is_to = 1'b1; e.per = m_per_out[idx]; e.ht = m_ht_out[idx];
         e.lk = 1'b0; e.er = m_locked[idx]; e.cyc = c;
         push(idx, e);
         m_locked[idx] = 1'b0;
         m_mode[idx] = 1;
         m_streak[idx] = 0;
         m_last_evt[idx] = c;
      end
      if (v) m_high[idx]++;
      m_prev[idx] = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clk_in0 = lvl[0];
      clk_in8 = lvl[1];
      model_step(0, lvl[0], cyc);
      model_step(1, lvl[1], cyc);
   endtask

   task automatic seg(input int idx, input int h, input int l, input int reps);
      repeat (reps) begin
         lvl[idx] = 1'b1;
         repeat (h) tick();
         lvl[idx] = 1'b0;
         repeat (l) tick();
      end
   endtask

   task automatic hold(input int idx, input bit v, input int n);
      lvl[idx] = v;
      repeat (n) tick();
   endtask

   task automatic mon_inst(input int idx, input logic mv, input logic to, input logic er,
                           input logic lk, input logic [15:0] per, input logic [15:0] ht);
      exp_t e;
      bit have;
      // anything past its due cycle was never presented by the DUT
      while (((idx == 0) ? exp_q0.size() : exp_q1.size()) > 0 &&
             (((idx == 0) ? exp_q0[0].cyc : exp_q1[0].cyc) + LAT) < cyc) begin
         e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         checks++; failures++;
         $display("FAIL missing_event[%0d] cyc=%0d expected timeout=%0b period=%0d", idx, cyc, e.is_to, e.per);
      end
      if (mv || to) begin
         have = ((idx == 0) ? exp_q0.size() : exp_q1.size()) > 0;
         if (!have) begin
            checks++; failures++;
            $display("FAIL unexpected_event[%0d] cyc=%0d actual meas_valid=%0b timeout=%0b expected none", idx, cyc, mv, to);
         end else begin
            e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("meas_valid", idx, mv, !e.is_to);
            chk("timeout", idx, to, e.is_to);
            chk("period", idx, per, e.per);
            chk("high_time", idx, ht, e.ht);
            chk("locked", idx, lk, e.lk);
            chk("err", idx, er, e.er);
            chk("latency", idx, cyc - e.cyc, LAT);
         end
      end else if (er) begin
         checks++; failures++;
         $display("FAIL lone_err[%0d] cyc=%0d actual err=1 expected err only with meas_valid/timeout", idx, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever a meter presents a result
   always @(negedge clk) begin
      if (!rst) begin
         mon_inst(0, mv0, to0, er0, lk0, per0, ht0);
         mon_inst(1, mv8, to8, er8, lk8, per8, ht8);
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_period"}, 0, per0, 0);     chk({tag, "_period"}, 1, per8, 0);
      chk({tag, "_high_time"}, 0, ht0, 0);   chk({tag, "_high_time"}, 1, ht8, 0);
      chk({tag, "_meas_valid"}, 0, mv0, 0);  chk({tag, "_meas_valid"}, 1, mv8, 0);
      chk({tag, "_locked"}, 0, lk0, 0);      chk({tag, "_locked"}, 1, lk8, 0);
      chk({tag, "_err"}, 0, er0, 0);         chk({tag, "_err"}, 1, er8, 0);
      chk({tag, "_timeout"}, 0, to0, 0);     chk({tag, "_timeout"}, 1, to8, 0);
   endtask

   initial begin
      int n, h, r;
      max_p[0] = 1023;
      max_p[1] = 8;
      lvl[0] = 1'b0; lvl[1] = 1'b0;
      clk_in0 = 1'b0; clk_in8 = 1'b0;
      rst = 1'b0;
      model_reset();
      #1 rst = 1'b1;
      #1 chk_zero("reset");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      // divide-by-6, divide-by-5, then an injected 8 and a sustained 8
      seg(0, 3, 3, 20);
      seg(0, 2, 3, 6);
      seg(0, 3, 3, 5);
      seg(0, 4, 4, 1);
      seg(0, 3, 3, 4);
      seg(0, 4, 4, 5);
      seg(0, 3, 3, 5);
      // stuck low while locked: one timeout 1023 cycles after the last rise, then relock
      hold(0, 1'b0, 1100);
      seg(0, 3, 3, 6);
      // random divider ratios and duty cycles
      for (int k = 0; k < 4; k++) begin
         n = $urandom_range(12, 2);
         h = $urandom_range(n - 1, 1);
         r = $urandom_range(6, 3);
         seg(0, h, n - h, r);
      end
      // MAX_PERIOD=8 meter: period 8 is valid, period 9 times out, stuck high/low repeats
      seg(1, 4, 4, 5);
      seg(1, 4, 5, 3);
      hold(1, 1'b0, 20);
      hold(1, 1'b1, 20);
      hold(1, 1'b0, 12);
      seg(1, 3, 4, 5);
      hold(1, 1'b0, 3);

      // asynchronous reset in the low phase while locked
      seg(0, 3, 3, 5);
      chk("locked_before_reset", 0, lk0, m_locked[0]);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_zero("async_reset");
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      seg(0, 3, 3, 5);

      repeat (6) @(posedge clk);
      #2;
      chk("queue_empty", 0, exp_q0.size(), 0);
      chk("queue_empty", 1, exp_q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
